// File: rtl/dot_product_feeder.sv
// Feeder stage for the TinyML accumulator: turns a job of signed operand pairs into
// registered products plus en/rst strobes so the accumulator's Q holds the dot product at done.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting operand pairs, one product per handshake
// ZERO  | empty job: load 0 into the accumulator
// DRAIN | last product presented to the accumulator
// DONE  | accumulator Q holds the final sum
module dot_product_feeder #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic [31:0]      acc_d,
    output logic             acc_en,
    output logic             acc_rst,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, RUN, ZERO, DRAIN, DONE} state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      acc_d_q, acc_d_d;
    logic             en_q, en_d;
    logic             rst_flag_q, rst_flag_d;

    logic signed [31:0] a_ext, b_ext, prod;

    // Sign-extend to 32 bits first; the low 32 bits of the product are exact for 16x16.
    assign a_ext = {{16{a[15]}}, a};
    assign b_ext = {{16{b[15]}}, b};
    assign prod  = a_ext * b_ext;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        acc_d_d    = acc_d_q;
        en_d       = 1'b0;
        rst_flag_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        count_d = '0;
                        state_d = RUN;
                    end else begin
                        acc_d_d    = '0;
                        en_d       = 1'b1;
                        rst_flag_d = 1'b1;
                        state_d    = ZERO;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    acc_d_d    = prod;
                    en_d       = 1'b1;
                    // The first product of a job masks whatever sum the accumulator still holds.
                    rst_flag_d = (count_q == '0);
                    count_d    = count_q + ONE;
                    if (count_q == len_q - ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            ZERO:    state_d = DONE;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            len_q      <= '0;
            acc_d_q    <= '0;
            en_q       <= 1'b0;
            rst_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            acc_d_q    <= acc_d_d;
            en_q       <= en_d;
            rst_flag_q <= rst_flag_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign in_ready = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign acc_d    = acc_d_q;
    assign acc_en   = en_q;
    assign acc_rst  = rst_flag_q;

endmodule
